// File: rtl/gs_mix_pkg.sv
// Shared defaults, FSM encoding and width helper for the gs_mixer block.
// Imported by the top and by the MAC sub-module.
package gs_mix_pkg;

  localparam int DEF_NUM_CH   = 4;
  localparam int DEF_SAMPLE_W = 8;
  localparam int DEF_VOL_W    = 6;
  localparam int DEF_OUT_W    = 9;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_PUBLISH = 2'd2
  } state_e;

  // Ceiling log2. Used for constant widths only.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/gs_mac.sv
// Shared multiplier feeding two independently gated accumulators.
// sum_*_o is the value the accumulator takes on an enabled edge.
module gs_mac
  import gs_mix_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int VOL_W    = DEF_VOL_W,
  parameter int ACC_W    = DEF_SAMPLE_W + DEF_VOL_W + 2
) (
  input  logic                clk_sys,
  input  logic                areset_n,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic [VOL_W-1:0]    vol_i,
  input  logic                add_l_i,
  input  logic                add_r_i,
  output logic [ACC_W-1:0]    sum_l_o,
  output logic [ACC_W-1:0]    sum_r_o
);

  localparam int PROD_W = SAMPLE_W + VOL_W;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_l_q, acc_l_d;
  logic [ACC_W-1:0]  acc_r_q, acc_r_d;

  assign prod = PROD_W'(sample_i) * PROD_W'(vol_i);

  always_comb begin
    sum_l_o = acc_l_q + (add_l_i ? ACC_W'(prod) : '0);
    sum_r_o = acc_r_q + (add_r_i ? ACC_W'(prod) : '0);
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    if (clr_i) begin
      acc_l_d = '0;
      acc_r_d = '0;
    end else if (en_i) begin
      acc_l_d = sum_l_o;
      acc_r_d = sum_r_o;
    end
  end

  always_ff @(posedge clk_sys or negedge areset_n) begin
    if (!areset_n) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
    end else begin
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
    end
  end

endmodule

// File: rtl/gs_mixer.sv
// Multi-channel volume/pan mixer: snapshots inputs on a strobe, accumulates
// one channel per cycle through a shared MAC, then publishes saturated sums.
module gs_mixer
  import gs_mix_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int VOL_W    = DEF_VOL_W,
  parameter int OUT_W    = DEF_OUT_W
) (
  input  logic                       clk_sys,
  input  logic                       areset_n,
  input  logic                       sample_stb,
  input  logic [NUM_CH*SAMPLE_W-1:0] ch_sample,
  input  logic [NUM_CH*VOL_W-1:0]    ch_vol,
  input  logic [NUM_CH-1:0]          pan_l,
  input  logic [NUM_CH-1:0]          pan_r,
  input  logic                       mute,
  input  logic                       overrun_clr,
  output logic [OUT_W-1:0]           out_l,
  output logic [OUT_W-1:0]           out_r,
  output logic                       out_valid,
  output logic                       busy,
  output logic                       overrun
);

  localparam int     IDX_W   = clog2(NUM_CH);
  localparam int     ACC_W   = SAMPLE_W + VOL_W + IDX_W;
  localparam longint OUT_MAX = (64'd1 << OUT_W) - 64'd1;

  state_e                     state_q;
  logic [1:0]                 rst_sync_q;
  logic [NUM_CH*SAMPLE_W-1:0] samp_q;
  logic [NUM_CH*VOL_W-1:0]    vol_q;
  logic [NUM_CH-1:0]          pan_l_q, pan_r_q;
  logic                       mute_q;
  logic [IDX_W-1:0]           ch_idx_q;
  logic [OUT_W-1:0]           out_l_q, out_r_q, out_l_d, out_r_d;
  logic                       out_valid_q, busy_q, overrun_q;

  logic                       accept;
  logic                       last_ch;
  logic [SAMPLE_W-1:0]        cur_sample;
  logic [VOL_W-1:0]           cur_vol;
  logic [ACC_W-1:0]           sum_l, sum_r;

  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] acc);
    logic [ACC_W-1:0] sh;
    sh = acc >> VOL_W;
    if (64'(sh) > OUT_MAX) return '1;
    return OUT_W'(sh);
  endfunction

  // Deassertion is retimed so a strobe cannot race the reset release.
  always_ff @(posedge clk_sys or negedge areset_n) begin
    if (!areset_n) rst_sync_q <= 2'b00;
    else           rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign accept     = sample_stb && rst_sync_q[1] && (state_q == ST_IDLE);
  assign last_ch    = (ch_idx_q == IDX_W'(NUM_CH - 1));
  assign cur_sample = samp_q[int'(ch_idx_q)*SAMPLE_W +: SAMPLE_W];
  assign cur_vol    = vol_q[int'(ch_idx_q)*VOL_W +: VOL_W];

  gs_mac #(
    .SAMPLE_W(SAMPLE_W),
    .VOL_W   (VOL_W),
    .ACC_W   (ACC_W)
  ) u_mac (
    .clk_sys (clk_sys),
    .areset_n(areset_n),
    .clr_i   (accept),
    .en_i    (state_q == ST_ACCUM),
    .sample_i(cur_sample),
    .vol_i   (cur_vol),
    .add_l_i (pan_l_q[ch_idx_q]),
    .add_r_i (pan_r_q[ch_idx_q]),
    .sum_l_o (sum_l),
    .sum_r_o (sum_r)
  );

  // Published values are taken from the MAC sums on the last channel's edge,
  // so the result is already registered during the PUBLISH cycle.
  always_comb begin
    out_l_d = mute_q ? '0 : sat(sum_l);
    out_r_d = mute_q ? '0 : sat(sum_r);
  end

  always_ff @(posedge clk_sys or negedge areset_n) begin
    if (!areset_n) begin
      state_q     <= ST_IDLE;
      samp_q      <= '0;
      vol_q       <= '0;
      pan_l_q     <= '0;
      pan_r_q     <= '0;
      mute_q      <= 1'b0;
      ch_idx_q    <= '0;
      out_l_q     <= '0;
      out_r_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (sample_stb && busy_q) overrun_q <= 1'b1;
      else if (overrun_clr)     overrun_q <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            samp_q   <= ch_sample;
            vol_q    <= ch_vol;
            pan_l_q  <= pan_l;
            pan_r_q  <= pan_r;
            mute_q   <= mute;
            ch_idx_q <= '0;
            busy_q   <= 1'b1;
            state_q  <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          if (last_ch) begin
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= 1'b1;
            state_q     <= ST_PUBLISH;
          end else begin
            ch_idx_q <= ch_idx_q + IDX_W'(1);
          end
        end
        ST_PUBLISH: begin
          busy_q   <= 1'b0;
          ch_idx_q <= '0;
          state_q  <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_l     = out_l_q;
  assign out_r     = out_r_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_gs_mixer.sv
// Self-checking bench for gs_mixer: vector table plus scoreboard of expected
// mixes, with hand sequences for timing, overrun, mute, reset and NUM_CH=8.
module tb_gs_mixer;

  typedef struct {
    logic [31:0] s;
    logic [23:0] v;
    logic [3:0]  pl;
    logic [3:0]  pr;
    logic        m;
    int          el;
    int          er;
  } vec_t;

  typedef struct {
    int l;
    int r;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        areset_n = 1'b0;
  logic        sample_stb = 1'b0;
  logic [31:0] ch_sample = '0;
  logic [23:0] ch_vol = '0;
  logic [3:0]  pan_l = '0, pan_r = '0;
  logic        mute = 1'b0, overrun_clr = 1'b0;
  logic [8:0]  out_l, out_r;
  logic        out_valid, busy, overrun;

  logic        stb8 = 1'b0;
  logic [63:0] ch_sample8 = '0;
  logic [47:0] ch_vol8 = '0;
  logic [7:0]  pan_l8 = '0, pan_r8 = '0;
  logic        mute8 = 1'b0, clr8 = 1'b0;
  logic [8:0]  out_l8, out_r8;
  logic        out_valid8, busy8, overrun8;

  int   errors = 0;
  int   checks = 0;
  int   vcount = 0;
  exp_t sb_q[$];
  vec_t vecs[6];

  always #5 clk_sys = ~clk_sys;

  gs_mixer dut (
    .clk_sys(clk_sys), .areset_n(areset_n), .sample_stb(sample_stb),
    .ch_sample(ch_sample), .ch_vol(ch_vol), .pan_l(pan_l), .pan_r(pan_r),
    .mute(mute), .overrun_clr(overrun_clr), .out_l(out_l), .out_r(out_r),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  gs_mixer #(.NUM_CH(8)) dut8 (
    .clk_sys(clk_sys), .areset_n(areset_n), .sample_stb(stb8),
    .ch_sample(ch_sample8), .ch_vol(ch_vol8), .pan_l(pan_l8), .pan_r(pan_r8),
    .mute(mute8), .overrun_clr(clr8), .out_l(out_l8), .out_r(out_r8),
    .out_valid(out_valid8), .busy(busy8), .overrun(overrun8)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t model(input logic [31:0] s, input logic [23:0] v,
                                 input logic [3:0] pl, input logic [3:0] pr,
                                 input logic m);
    vec_t r;
    int al, ar, p;
    al = 0;
    ar = 0;
    for (int c = 0; c < 4; c++) begin
      p = int'(s[c*8 +: 8]) * int'(v[c*6 +: 6]);
      if (pl[c]) al += p;
      if (pr[c]) ar += p;
    end
    al = al / 64;
    ar = ar / 64;
    if (al > 511) al = 511;
    if (ar > 511) ar = 511;
    if (m) begin
      al = 0;
      ar = 0;
    end
    r = '{s, v, pl, pr, m, al, ar};
    return r;
  endfunction

  always @(negedge clk_sys) begin
    exp_t e;
    if (areset_n && out_valid) begin
      vcount++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got out_valid=1 expected no pending mix");
      end else begin
        e = sb_q.pop_front();
        chk("mix_out_l", 32'(out_l), e.l);
        chk("mix_out_r", 32'(out_r), e.r);
      end
    end
  end

  // Called at a falling edge; returns one cycle later with the strobe dropped.
  task automatic start_mix(input vec_t vc);
    exp_t e;
    ch_sample  = vc.s;
    ch_vol     = vc.v;
    pan_l      = vc.pl;
    pan_r      = vc.pr;
    mute       = vc.m;
    sample_stb = 1'b1;
    e.l = vc.el;
    e.r = vc.er;
    sb_q.push_back(e);
    @(negedge clk_sys);
    sample_stb = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 40) begin
      @(negedge clk_sys);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s_timeout: got still busy after %0d cycles expected idle", nm, n);
    end
  endtask

  initial begin
    vec_t vr;
    int   v0, k, found;

    vecs[0] = '{32'hFFFF_FFFF, {4{6'd63}}, 4'b0011, 4'b1100, 1'b0, 502, 502};
    vecs[1] = '{32'hFFFF_FFFF, {4{6'd63}}, 4'b1111, 4'b0000, 1'b0, 511, 0};
    vecs[2] = '{32'h8040_2010, {6'd32, 6'd16, 6'd8, 6'd4}, 4'b0101, 4'b1010, 1'b0, 17, 68};
    vecs[3] = '{32'h4040_4040, {4{6'd1}}, 4'b0001, 4'b0001, 1'b0, 1, 1};
    vecs[4] = '{32'hFFFF_FFFF, {4{6'd63}}, 4'b0011, 4'b1100, 1'b1, 0, 0};
    vecs[5] = '{32'h005B_FFFF, {6'd0, 6'd7, 6'd63, 6'd63}, 4'b0111, 4'b0011, 1'b0, 511, 502};

    repeat (2) @(negedge clk_sys);
    chk("rst_out_l", 32'(out_l), 0);
    chk("rst_out_r", 32'(out_r), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_overrun", 32'(overrun), 0);
    areset_n = 1'b1;
    repeat (4) @(negedge clk_sys);

    // Cycle-accurate busy/out_valid profile on the first vector.
    start_mix(vecs[0]);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("busy_T%0d", i + 1), 32'(busy), (i < 5) ? 1 : 0);
      chk($sformatf("valid_T%0d", i + 1), 32'(out_valid), (i == 4) ? 1 : 0);
      @(negedge clk_sys);
    end
    wait_idle("v0");

    for (int i = 1; i < 6; i++) begin
      start_mix(vecs[i]);
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("hold_l_%0d", i), 32'(out_l), vecs[i].el);
      chk($sformatf("hold_r_%0d", i), 32'(out_r), vecs[i].er);
    end

    for (int i = 0; i < 6; i++) begin
      vr = model($urandom, 24'($urandom), 4'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0));
      start_mix(vr);
      wait_idle("rand");
    end

    // Second strobe two cycles in: dropped, flagged, single result.
    v0 = vcount;
    start_mix(vecs[2]);
    @(negedge clk_sys);
    sample_stb = 1'b1;
    @(negedge clk_sys);
    sample_stb = 1'b0;
    chk("overrun_set", 32'(overrun), 1);
    wait_idle("overrun");
    repeat (3) @(negedge clk_sys);
    chk("overrun_one_valid", 32'(vcount - v0), 1);
    chk("overrun_sticky", 32'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge clk_sys);
    overrun_clr = 1'b0;
    chk("overrun_cleared", 32'(overrun), 0);

    // Strobe during the PUBLISH cycle.
    start_mix(vecs[3]);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_valid) found = 1;
      else @(negedge clk_sys);
    end
    chk("publish_reached", 32'(found), 1);
    sample_stb = 1'b1;
    @(negedge clk_sys);
    sample_stb = 1'b0;
    chk("publish_stb_overrun", 32'(overrun), 1);
    chk("publish_stb_ignored", 32'(busy), 0);

    // Clear and new overrun in the same cycle: set wins.
    start_mix(vecs[3]);
    sample_stb  = 1'b1;
    overrun_clr = 1'b1;
    @(negedge clk_sys);
    sample_stb  = 1'b0;
    overrun_clr = 1'b0;
    chk("clr_vs_set", 32'(overrun), 1);
    wait_idle("clr_vs_set");
    overrun_clr = 1'b1;
    @(negedge clk_sys);
    overrun_clr = 1'b0;

    // Muted mix with inputs changed right after the strobe.
    start_mix(vecs[4]);
    ch_sample = vecs[2].s;
    ch_vol    = vecs[2].v;
    pan_l     = vecs[2].pl;
    pan_r     = vecs[2].pr;
    mute      = 1'b0;
    wait_idle("mute");
    chk("mute_out_l", 32'(out_l), 0);
    chk("mute_out_r", 32'(out_r), 0);
    start_mix(vecs[2]);
    wait_idle("after_mute");

    // Reset in the middle of a mix.
    v0 = vcount;
    start_mix(vecs[0]);
    sample_stb = 1'b1;
    @(negedge clk_sys);
    sample_stb = 1'b0;
    chk("pre_rst_overrun", 32'(overrun), 1);
    areset_n = 1'b0;
    sb_q.delete();
    #1;
    chk("midrst_out_l", 32'(out_l), 0);
    chk("midrst_out_r", 32'(out_r), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_overrun", 32'(overrun), 0);
    repeat (6) @(negedge clk_sys);
    chk("midrst_no_valid", 32'(vcount - v0), 0);

    // Strobe on the first edge after release is not accepted.
    areset_n   = 1'b1;
    sample_stb = 1'b1;
    @(negedge clk_sys);
    sample_stb = 1'b0;
    chk("release_stb_busy", 32'(busy), 0);
    chk("release_stb_overrun", 32'(overrun), 0);
    repeat (3) @(negedge clk_sys);
    start_mix(vecs[2]);
    wait_idle("post_reset");

    // Eight-channel instance: channel 7 alone, right side.
    ch_sample8 = 64'h80 << 56;
    ch_vol8    = 48'd32 << 42;
    pan_r8     = 8'h80;
    stb8       = 1'b1;
    @(negedge clk_sys);
    stb8 = 1'b0;
    k = -1;
    for (int i = 0; i < 16; i++) begin
      if (out_valid8 && k < 0) begin
        k = i;
        chk("ch8_out_r", 32'(out_r8), 64);
        chk("ch8_out_l", 32'(out_l8), 0);
      end
      @(negedge clk_sys);
    end
    chk("ch8_valid_cycle", 32'(k), 8);

    chk("sb_empty", 32'(sb_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
